vga_timing_gen: RTL and testbench

Parametrised VGA/DVI raster timing generator; successor to the fixed 640x480 controller. Produces pixel/line counters, sync, blank, and frame/line strobes for the pixel pipeline and VGA pins. Adds the following:
- a programmable pixel-clock divider
- per-axis sync polarity
- a run enable
- a sync/blank delay line that aligns syncs with a multi-cycle pixel pipeline

---
 rtl/vga_pkg.sv | 39 +++
 rtl/vga_axis_counter.sv | 51 +++++
 rtl/vga_timing_gen.sv | 133 +++++++++++++
 tb/tb_vga_timing_gen.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing types, standard mode constants and axis helpers.
package vga_pkg;

    localparam int unsigned TW = 16;

    typedef struct packed {
        logic [TW-1:0] active;
        logic [TW-1:0] fp;
        logic [TW-1:0] sync;
        logic [TW-1:0] bp;
    } vga_axis_t;

    typedef struct packed {
        vga_axis_t h;
        vga_axis_t v;
    } vga_timing_t;

    // Decoded per-pixel controls; all-zero is the deasserted state
    typedef struct packed {
        logic hs;
        logic vs;
        logic act;
    } vga_ctl_t;

    localparam vga_timing_t VGA_640x480_60 = '{
        h: '{active: 16'd640, fp: 16'd16, sync: 16'd96,  bp: 16'd48},
        v: '{active: 16'd480, fp: 16'd10, sync: 16'd2,   bp: 16'd33}
    };

    localparam vga_timing_t VGA_800x600_60 = '{
        h: '{active: 16'd800, fp: 16'd40, sync: 16'd128, bp: 16'd88},
        v: '{active: 16'd600, fp: 16'd1,  sync: 16'd4,   bp: 16'd23}
    };

    function automatic int unsigned axis_total(input vga_axis_t a);
        return 32'(a.active) + 32'(a.fp) + 32'(a.sync) + 32'(a.bp);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrapping position counter for one raster axis with its sync/active window decode.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned MAX    = 800,
    parameter int unsigned CW     = 10,
    parameter int unsigned ACTIVE = 640,
    parameter int unsigned FP     = 16,
    parameter int unsigned SYNC   = 96
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          wrap,
    output logic          in_sync,
    output logic          in_active
);

    localparam logic [CW-1:0] LAST    = CW'(MAX - 1);
    localparam logic [CW:0]   ACT_END = (CW+1)'(ACTIVE);
    localparam logic [CW:0]   SYN_BEG = (CW+1)'(ACTIVE + FP);
    localparam logic [CW:0]   SYN_END = (CW+1)'(ACTIVE + FP + SYNC);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [CW:0]   count_ext;

    always_comb begin
        count_d = count_q;
        if (inc) begin
            count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Widened compare so a window ending exactly at 2^CW still decodes correctly
    assign count_ext = {1'b0, count_q};
    assign count     = count_q;
    assign wrap      = inc && (count_q == LAST);
    assign in_sync   = (count_ext >= SYN_BEG) && (count_ext < SYN_END);
    assign in_active = count_ext < ACT_END;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/DVI raster timing generator with pixel-clock divider,
// run enable, per-axis sync polarity and a pixel-aligned sync/blank delay line.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned HACTIVE    = 640,
    parameter int unsigned HFP        = 16,
    parameter int unsigned HSYN       = 96,
    parameter int unsigned HBP        = 48,
    parameter int unsigned VACTIVE    = 480,
    parameter int unsigned VFP        = 10,
    parameter int unsigned VSYN       = 2,
    parameter int unsigned VBP        = 33,
    parameter int unsigned HSYNC_POL  = 0,
    parameter int unsigned VSYNC_POL  = 0,
    parameter int unsigned CLK_DIV    = 1,
    parameter int unsigned PIPE_DELAY = 0,
    parameter int unsigned CW         = 10
) (
    input  logic          vgaclk,
    input  logic          reset_n,
    input  logic          en,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          pix_tick,
    output logic          hsync,
    output logic          vsync,
    output logic          blank_b,
    output logic          line_start,
    output logic          frame_start
);

    localparam vga_axis_t H_AXIS = '{active: 16'(HACTIVE), fp: 16'(HFP),
                                     sync: 16'(HSYN), bp: 16'(HBP)};
    localparam vga_axis_t V_AXIS = '{active: 16'(VACTIVE), fp: 16'(VFP),
                                     sync: 16'(VSYN), bp: 16'(VBP)};
    localparam int unsigned HMAX = axis_total(H_AXIS);
    localparam int unsigned VMAX = axis_total(V_AXIS);
    localparam int unsigned DW   = 4;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic HPOL = 1'(HSYNC_POL);
    localparam logic VPOL = 1'(VSYNC_POL);

    if (CLK_DIV == 0 || CLK_DIV > 16) begin : g_err_div
        $error("vga_timing_gen: CLK_DIV must be in 1..16");
    end
    if (PIPE_DELAY > 7) begin : g_err_pipe
        $error("vga_timing_gen: PIPE_DELAY must be in 0..7");
    end
    if ((64'd1 << CW) < 64'(HMAX) || (64'd1 << CW) < 64'(VMAX)) begin : g_err_cw
        $error("vga_timing_gen: CW too small for HMAX/VMAX");
    end

    logic [DW-1:0] div_q;
    logic [DW-1:0] div_d;
    logic          pix_tick_c;
    logic          h_wrap;
    logic          v_wrap;
    logic          h_sync;
    logic          v_sync;
    logic          h_act;
    logic          v_act;
    logic          line_q;
    logic          frame_q;
    vga_ctl_t      ctl_c;
    vga_ctl_t      ctl_out_c;

    always_comb begin
        div_d = div_q;
        if (en) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
        end
    end

    // Gated by reset_n so no tick is seen while reset is held with en high
    assign pix_tick_c = reset_n && en && (div_q == DIV_LAST);

    always_ff @(posedge vgaclk or negedge reset_n) begin
        if (!reset_n) begin
            div_q   <= '0;
            line_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            line_q  <= h_wrap;
            frame_q <= v_wrap;
        end
    end

    vga_axis_counter #(
        .MAX(HMAX), .CW(CW), .ACTIVE(HACTIVE), .FP(HFP), .SYNC(HSYN)
    ) u_h (
        .clk(vgaclk), .rst_n(reset_n), .inc(pix_tick_c),
        .count(x), .wrap(h_wrap), .in_sync(h_sync), .in_active(h_act)
    );

    vga_axis_counter #(
        .MAX(VMAX), .CW(CW), .ACTIVE(VACTIVE), .FP(VFP), .SYNC(VSYN)
    ) u_v (
        .clk(vgaclk), .rst_n(reset_n), .inc(h_wrap),
        .count(y), .wrap(v_wrap), .in_sync(v_sync), .in_active(v_act)
    );

    assign ctl_c = '{hs: h_sync, vs: v_sync, act: h_act && v_act};

    if (PIPE_DELAY == 0) begin : g_nodelay
        assign ctl_out_c = ctl_c;
    end else begin : g_delay
        vga_ctl_t [PIPE_DELAY-1:0] pipe_q;

        // Shifts once per pixel so the lag is in pixels, not vgaclk cycles
        always_ff @(posedge vgaclk or negedge reset_n) begin
            if (!reset_n) begin
                pipe_q <= '0;
            end else if (pix_tick_c) begin
                pipe_q[0] <= ctl_c;
                for (int i = 1; i < int'(PIPE_DELAY); i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
        end

        assign ctl_out_c = pipe_q[PIPE_DELAY-1];
    end

    assign pix_tick    = pix_tick_c;
    assign hsync       = ctl_out_c.hs ? HPOL : ~HPOL;
    assign vsync       = ctl_out_c.vs ? VPOL : ~VPOL;
    assign blank_b     = reset_n && ctl_out_c.act;
    assign line_start  = line_q;
    assign frame_start = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Table-driven bench for vga_timing_gen over several parameter sets.
module tb_vga_timing_gen;

    logic       clk = 1'b0;
    logic [4:0] rst_n;
    logic [4:0] en;
    logic [9:0] x_w [5];
    logic [9:0] y_w [5];
    logic [4:0] tick_w, hs_w, vs_w, bl_w, ls_w, fs_w;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    // 0: defaults, 1: CLK_DIV=4, 2: PIPE_DELAY=3 + active-high hsync, 3: CLK_DIV=2, 4: tiny raster
    vga_timing_gen u_def (
        .vgaclk(clk), .reset_n(rst_n[0]), .en(en[0]), .x(x_w[0]), .y(y_w[0]),
        .pix_tick(tick_w[0]), .hsync(hs_w[0]), .vsync(vs_w[0]), .blank_b(bl_w[0]),
        .line_start(ls_w[0]), .frame_start(fs_w[0]));

    vga_timing_gen #(.CLK_DIV(4)) u_div4 (
        .vgaclk(clk), .reset_n(rst_n[1]), .en(en[1]), .x(x_w[1]), .y(y_w[1]),
        .pix_tick(tick_w[1]), .hsync(hs_w[1]), .vsync(vs_w[1]), .blank_b(bl_w[1]),
        .line_start(ls_w[1]), .frame_start(fs_w[1]));

    vga_timing_gen #(.PIPE_DELAY(3), .HSYNC_POL(1)) u_pipe (
        .vgaclk(clk), .reset_n(rst_n[2]), .en(en[2]), .x(x_w[2]), .y(y_w[2]),
        .pix_tick(tick_w[2]), .hsync(hs_w[2]), .vsync(vs_w[2]), .blank_b(bl_w[2]),
        .line_start(ls_w[2]), .frame_start(fs_w[2]));

    vga_timing_gen #(.CLK_DIV(2)) u_div2 (
        .vgaclk(clk), .reset_n(rst_n[3]), .en(en[3]), .x(x_w[3]), .y(y_w[3]),
        .pix_tick(tick_w[3]), .hsync(hs_w[3]), .vsync(vs_w[3]), .blank_b(bl_w[3]),
        .line_start(ls_w[3]), .frame_start(fs_w[3]));

    vga_timing_gen #(.HACTIVE(8), .HFP(2), .HSYN(3), .HBP(3),
                     .VACTIVE(4), .VFP(1), .VSYN(2), .VBP(1)) u_small (
        .vgaclk(clk), .reset_n(rst_n[4]), .en(en[4]), .x(x_w[4]), .y(y_w[4]),
        .pix_tick(tick_w[4]), .hsync(hs_w[4]), .vsync(vs_w[4]), .blank_b(bl_w[4]),
        .line_start(ls_w[4]), .frame_start(fs_w[4]));

    typedef struct {
        int   dut;
        int   cyc;
        int   x;
        int   y;
        logic tick;
        logic hs;
        logic vs;
        logic bl;
        logic ls;
        logic fs;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input int d, input int c, input int xx, input int yy, input logic t,
                       input logic hs, input logic vs, input logic bl, input logic ls,
                       input logic fs);
        vec_t v;
        v = '{dut: d, cyc: c, x: xx, y: yy, tick: t, hs: hs, vs: vs, bl: bl, ls: ls, fs: fs};
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic release_dut(input int d);
        @(negedge clk);
        rst_n[d] = 1'b1;
        #1;
        cyc = 0;
    endtask

    task automatic check_all(input string tag, input int d, input int xx, input int yy,
                             input logic t, input logic hs, input logic vs, input logic bl,
                             input logic ls, input logic fs);
        chk({tag, " x"},           32'(x_w[d]),   32'(xx));
        chk({tag, " y"},           32'(y_w[d]),   32'(yy));
        chk({tag, " pix_tick"},    32'(tick_w[d]), 32'(t));
        chk({tag, " hsync"},       32'(hs_w[d]),  32'(hs));
        chk({tag, " vsync"},       32'(vs_w[d]),  32'(vs));
        chk({tag, " blank_b"},     32'(bl_w[d]),  32'(bl));
        chk({tag, " line_start"},  32'(ls_w[d]),  32'(ls));
        chk({tag, " frame_start"}, 32'(fs_w[d]),  32'(fs));
    endtask

    task automatic run_table(input int d);
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].dut == d) begin
                while (cyc < vecs[i].cyc) step();
                check_all($sformatf("dut%0d cyc%0d", d, cyc), d, vecs[i].x, vecs[i].y,
                          vecs[i].tick, vecs[i].hs, vecs[i].vs, vecs[i].bl,
                          vecs[i].ls, vecs[i].fs);
            end
        end
    endtask

    initial begin
        rst_n = '0;
        en    = '1;

        //  dut cyc    x    y  tick hs vs bl ls fs
        add(0,    0,   0,   0, 1, 1, 1, 1, 0, 0);
        add(0,    1,   1,   0, 1, 1, 1, 1, 0, 0);
        add(0,  639, 639,   0, 1, 1, 1, 1, 0, 0);
        add(0,  640, 640,   0, 1, 1, 1, 0, 0, 0);
        add(0,  655, 655,   0, 1, 1, 1, 0, 0, 0);
        add(0,  656, 656,   0, 1, 0, 1, 0, 0, 0);
        add(0,  751, 751,   0, 1, 0, 1, 0, 0, 0);
        add(0,  752, 752,   0, 1, 1, 1, 0, 0, 0);
        add(0,  799, 799,   0, 1, 1, 1, 0, 0, 0);
        add(0,  800,   0,   1, 1, 1, 1, 1, 1, 0);
        add(0,  801,   1,   1, 1, 1, 1, 1, 0, 0);
        add(0, 1600,   0,   2, 1, 1, 1, 1, 1, 0);

        add(1,    0,   0,   0, 0, 1, 1, 1, 0, 0);
        add(1,    3,   0,   0, 1, 1, 1, 1, 0, 0);
        add(1,    4,   1,   0, 0, 1, 1, 1, 0, 0);
        add(1,    7,   1,   0, 1, 1, 1, 1, 0, 0);
        add(1,    8,   2,   0, 0, 1, 1, 1, 0, 0);
        add(1, 2626, 656,   0, 0, 0, 1, 0, 0, 0);
        add(1, 3199, 799,   0, 1, 1, 1, 0, 0, 0);
        add(1, 3200,   0,   1, 0, 1, 1, 1, 1, 0);
        add(1, 3201,   0,   1, 0, 1, 1, 1, 0, 0);
        add(1, 3203,   0,   1, 1, 1, 1, 1, 0, 0);
        add(1, 3204,   1,   1, 0, 1, 1, 1, 0, 0);

        add(2,    0,   0,   0, 1, 0, 1, 0, 0, 0);
        add(2,    2,   2,   0, 1, 0, 1, 0, 0, 0);
        add(2,    3,   3,   0, 1, 0, 1, 1, 0, 0);
        add(2,  642, 642,   0, 1, 0, 1, 1, 0, 0);
        add(2,  643, 643,   0, 1, 0, 1, 0, 0, 0);
        add(2,  658, 658,   0, 1, 0, 1, 0, 0, 0);
        add(2,  659, 659,   0, 1, 1, 1, 0, 0, 0);
        add(2,  754, 754,   0, 1, 1, 1, 0, 0, 0);
        add(2,  755, 755,   0, 1, 0, 1, 0, 0, 0);
        add(2,  800,   0,   1, 1, 0, 1, 0, 1, 0);
        add(2,  803,   3,   1, 1, 0, 1, 1, 0, 0);

        add(4,    0,   0,   0, 1, 1, 1, 1, 0, 0);
        add(4,   16,   0,   1, 1, 1, 1, 1, 1, 0);
        add(4,   63,  15,   3, 1, 1, 1, 0, 0, 0);
        add(4,   64,   0,   4, 1, 1, 1, 0, 1, 0);
        add(4,   80,   0,   5, 1, 1, 0, 0, 1, 0);
        add(4,   90,  10,   5, 1, 0, 0, 0, 0, 0);
        add(4,  111,  15,   6, 1, 1, 0, 0, 0, 0);
        add(4,  112,   0,   7, 1, 1, 1, 0, 1, 0);
        add(4,  128,   0,   0, 1, 1, 1, 1, 1, 1);
        add(4,  129,   1,   0, 1, 1, 1, 1, 0, 0);

        // Reset state with en held high on every instance
        repeat (3) step();
        for (int d = 0; d < 5; d++) begin
            check_all($sformatf("reset dut%0d", d), d, 0, 0, 1'b0,
                      (d == 2) ? 1'b0 : 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        end

        release_dut(0); run_table(0);
        release_dut(1); run_table(1);
        release_dut(2); run_table(2);
        release_dut(4); run_table(4);

        // Strobe cadence on the tiny raster: lines every 16, frames every 128
        while (cyc < 300) begin
            step();
            chk($sformatf("small ls cyc%0d", cyc), 32'(ls_w[4]), 32'(cyc % 16 == 0));
            chk($sformatf("small fs cyc%0d", cyc), 32'(fs_w[4]), 32'(cyc % 128 == 0));
        end

        // Asynchronous reset mid-frame, inside both sync windows
        while (cyc < 346) step();
        check_all("pre-async", 4, 10, 5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n[4] = 1'b0;
        #1;
        check_all("async reset", 4, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (2) step();
        release_dut(4);
        for (int i = 1; i < 16; i++) begin
            step();
            chk($sformatf("post-rel x%0d", i), 32'(x_w[4]), 32'(i));
            chk($sformatf("post-rel ls%0d", i), 32'(ls_w[4]), 32'd0);
            chk($sformatf("post-rel fs%0d", i), 32'(fs_w[4]), 32'd0);
        end
        step();
        chk("post-rel first line_start", 32'(ls_w[4]), 32'd1);
        chk("post-rel no frame_start", 32'(fs_w[4]), 32'd0);

        // Enable gap on CLK_DIV=2 at x=100 in the tick phase of the divider
        release_dut(3);
        while (cyc < 201) step();
        chk("gap pre x", 32'(x_w[3]), 32'd100);
        chk("gap pre tick", 32'(tick_w[3]), 32'd1);
        en[3] = 1'b0;
        #1;
        chk("gap tick drop", 32'(tick_w[3]), 32'd0);
        for (int i = 0; i < 37; i++) begin
            step();
            check_all($sformatf("gap %0d", i), 3, 100, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        en[3] = 1'b1;
        #1;
        chk("resume tick", 32'(tick_w[3]), 32'd1);
        chk("resume x", 32'(x_w[3]), 32'd100);
        step();
        chk("resume+1 x", 32'(x_w[3]), 32'd101);
        chk("resume+1 tick", 32'(tick_w[3]), 32'd0);
        step();
        chk("resume+2 tick", 32'(tick_w[3]), 32'd1);
        step();
        chk("resume+3 x", 32'(x_w[3]), 32'd102);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
